// File: rtl/input_debouncer_pkg.sv
// Shared constants and channel state type for the input debouncer.
package input_debouncer_pkg;

    localparam int DEFAULT_WIDTH         = 8;
    localparam int DEFAULT_STABLE_CYCLES = 500000;

    typedef enum logic {
        ST_STABLE,
        ST_PENDING
    } ch_state_e;

endpackage

// File: rtl/input_debouncer_if.sv
// Pin-side bundle of the debouncer: raw levels in, filtered levels, edge pulses and flag out.
interface input_debouncer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] debounced_export;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic             change_flag;
    logic             flag_ack;

    modport master (
        output raw_in, flag_ack,
        input  debounced_export, rise_pulse, fall_pulse, change_flag
    );

    modport slave (
        input  raw_in, flag_ack,
        output debounced_export, rise_pulse, fall_pulse, change_flag
    );
endinterface

// File: rtl/debounce_channel.sv
// One input bit: 2-FF synchronizer, stable-time filter FSM and registered edge pulses.
module debounce_channel
    import input_debouncer_pkg::*;
#(
    parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter logic RESET_BIT     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic debounced,
    output logic rise,
    output logic fall
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1, sync2;
    ch_state_e        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             accept;

    // cnt holds how many edges the mismatch has already been seen on
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        case (state)
            ST_STABLE: begin
                cnt_n = '0;
                if (sync2 != debounced) begin
                    if (STABLE_CYCLES == 1) begin
                        accept = 1'b1;
                    end else begin
                        state_n = ST_PENDING;
                        cnt_n   = CNT_W'(1);
                    end
                end
            end
            ST_PENDING: begin
                if (sync2 == debounced) begin
                    state_n = ST_STABLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    accept  = 1'b1;
                    state_n = ST_STABLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = ST_STABLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= RESET_BIT;
            sync2     <= RESET_BIT;
            debounced <= RESET_BIT;
            state     <= ST_STABLE;
            cnt       <= '0;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                debounced <= sync2;
            end
            rise <= accept & sync2;
            fall <= accept & ~sync2;
        end
    end
endmodule

// File: rtl/input_debouncer.sv
// Debounces WIDTH raw pins into clean levels, per-bit edge pulses and a sticky change flag.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int               WIDTH         = DEFAULT_WIDTH,
    parameter int               STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic            clk_clk,
    input  logic            reset_reset,
    input_debouncer_if.slave io
);
    logic [WIDTH-1:0] deb, rise, fall;
    logic             any_pulse;
    logic             flag_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .RESET_BIT    (RESET_VALUE[i])
        ) u_ch (
            .clk      (clk_clk),
            .rst      (reset_reset),
            .raw      (io.raw_in[i]),
            .debounced(deb[i]),
            .rise     (rise[i]),
            .fall     (fall[i])
        );
    end

    assign any_pulse = |(rise | fall);

    // Flag is visible in the pulse cycle itself; the register keeps it set even
    // when an ack lands in that same cycle.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= any_pulse | (flag_q & ~io.flag_ack);
        end
    end

    assign io.debounced_export = deb;
    assign io.rise_pulse       = rise;
    assign io.fall_pulse       = fall;
    assign io.change_flag      = flag_q | any_pulse;
endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer with STABLE_CYCLES=4: stimulus queues expected pulses, a monitor checks them.
module tb_input_debouncer;
    logic clk_clk;
    logic reset_reset;
    int   cyc;
    int   tests, fails;
    bit   mon_en;

    typedef struct {
        int         at;
        logic [7:0] rise;
        logic [7:0] fall;
        logic [7:0] deb;
        logic       flag;
    } exp_t;

    exp_t q[$];
    exp_t e;

    input_debouncer_if #(.WIDTH(8)) io ();

    input_debouncer #(
        .WIDTH        (8),
        .STABLE_CYCLES(4),
        .RESET_VALUE  (8'h00)
    ) dut (
        .clk_clk    (clk_clk),
        .reset_reset(reset_reset),
        .io         (io)
    );

    initial begin
        clk_clk = 1'b0;
        forever #5 clk_clk = ~clk_clk;
    end

    initial cyc = 0;
    always @(posedge clk_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Pulse expected 'off' cycles after the current negedge
    task automatic expect_pulse(input int off, input logic [7:0] r, input logic [7:0] f,
                                input logic [7:0] d);
        exp_t x;
        x.at = cyc + off; x.rise = r; x.fall = f; x.deb = d; x.flag = 1'b1;
        q.push_back(x);
    endtask

    task automatic ack();
        io.flag_ack = 1'b1;
        @(negedge clk_clk);
        io.flag_ack = 1'b0;
        check("ack_clears_flag", {7'd0, io.change_flag}, 8'h00);
    endtask

    always @(negedge clk_clk) begin
        if (mon_en && (|(io.rise_pulse | io.fall_pulse))) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse: cyc %0d rise %h fall %h deb %h",
                         cyc, io.rise_pulse, io.fall_pulse, io.debounced_export);
            end else begin
                e = q.pop_front();
                if (cyc != e.at || io.rise_pulse !== e.rise || io.fall_pulse !== e.fall ||
                    io.debounced_export !== e.deb || io.change_flag !== e.flag) begin
                    fails++;
                    $display("FAIL pulse_event: got cyc %0d rise %h fall %h deb %h flag %b, expected cyc %0d rise %h fall %h deb %h flag %b",
                             cyc, io.rise_pulse, io.fall_pulse, io.debounced_export, io.change_flag,
                             e.at, e.rise, e.fall, e.deb, e.flag);
                end
            end
        end
    end

    initial begin
        tests = 0; fails = 0; mon_en = 1'b0;
        reset_reset = 1'b1;
        io.raw_in   = 8'h00;
        io.flag_ack = 1'b0;

        // reset for three edges, then quiet for 20 cycles
        repeat (3) @(negedge clk_clk);
        reset_reset = 1'b0;
        mon_en = 1'b1;
        check("rst_deb",  io.debounced_export, 8'h00);
        check("rst_rise", io.rise_pulse, 8'h00);
        check("rst_fall", io.fall_pulse, 8'h00);
        check("rst_flag", {7'd0, io.change_flag}, 8'h00);
        repeat (20) @(negedge clk_clk);
        check("idle_deb",  io.debounced_export, 8'h00);
        check("idle_flag", {7'd0, io.change_flag}, 8'h00);

        // clean press on bit 0
        io.raw_in = 8'h01;
        expect_pulse(6, 8'h01, 8'h00, 8'h01);
        repeat (5) @(negedge clk_clk);
        check("press_not_yet", io.debounced_export, 8'h00);
        repeat (5) @(negedge clk_clk);
        check("press_deb",  io.debounced_export, 8'h01);
        check("press_flag", {7'd0, io.change_flag}, 8'h01);
        ack();

        // bounce on bit 3, then a clean hold
        for (int i = 0; i < 2; i++) begin
            io.raw_in = io.raw_in | 8'h08;
            repeat (2) @(negedge clk_clk);
            io.raw_in = io.raw_in & 8'hF7;
            repeat (2) @(negedge clk_clk);
        end
        check("bounce_no_change", io.debounced_export, 8'h01);
        io.raw_in = io.raw_in | 8'h08;
        expect_pulse(6, 8'h08, 8'h00, 8'h09);
        repeat (10) @(negedge clk_clk);
        check("bounce_deb", io.debounced_export, 8'h09);
        ack();

        // release everything
        io.raw_in = 8'h00;
        expect_pulse(6, 8'h00, 8'h09, 8'h00);
        repeat (10) @(negedge clk_clk);
        check("release_deb", io.debounced_export, 8'h00);
        ack();

        // simultaneous rises
        io.raw_in = 8'hA5;
        expect_pulse(6, 8'hA5, 8'h00, 8'hA5);
        repeat (10) @(negedge clk_clk);
        check("simul_deb", io.debounced_export, 8'hA5);
        ack();

        // ack lands in the same cycle as fall_pulse[7]
        io.raw_in = 8'h25;
        expect_pulse(6, 8'h00, 8'h80, 8'h25);
        repeat (6) @(negedge clk_clk);
        io.flag_ack = 1'b1;
        @(negedge clk_clk);
        check("ack_collision_flag", {7'd0, io.change_flag}, 8'h01);
        @(negedge clk_clk);
        io.flag_ack = 1'b0;
        check("ack_alone_flag", {7'd0, io.change_flag}, 8'h00);

        io.raw_in = 8'h00;
        expect_pulse(6, 8'h00, 8'h25, 8'h00);
        repeat (10) @(negedge clk_clk);
        ack();

        // reset while bit 1 is pending
        io.raw_in = 8'h02;
        repeat (3) @(negedge clk_clk);
        reset_reset = 1'b1;
        expect_pulse(7, 8'h02, 8'h00, 8'h02);
        @(negedge clk_clk);
        reset_reset = 1'b0;
        check("midrst_deb",  io.debounced_export, 8'h00);
        check("midrst_flag", {7'd0, io.change_flag}, 8'h00);
        repeat (10) @(negedge clk_clk);
        check("midrst_final_deb", io.debounced_export, 8'h02);

        @(negedge clk_clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL missing_pulses: %0d expected events never seen, expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
Conditions the raw board switches and buttons before they enter the processor system's PIO input port (inputs_export[7:0]).
- Each bit gets a 2-FF synchronizer and a stable-time debounce filter.
- Produces single-cycle rise and fall pulses per bit.
- Produces a sticky change flag for software polling or interrupt use.
- Sits between the top-level pins and the system instance, in the clk_clk domain.

Parameters:
WIDTH, 8, number of input channels
STABLE_CYCLES, 500000, consecutive cycles a new level must persist before acceptance (10 ms at 50 MHz); legal range >= 1
RESET_VALUE, 8'h00, value loaded into debounced_export and both synchronizer stages at reset
CNT_W, $clog2(STABLE_CYCLES+1), counter width (derived, do not override)

Ports:
clk_clk  in  1  system clock; single clock domain
reset_reset  in  1  synchronous, active-high reset
raw_in  in  WIDTH  asynchronous switch/button levels from pins
debounced_export  out  WIDTH  filtered levels; drives system inputs_export
rise_pulse  out  WIDTH  one-cycle pulse per bit on accepted 0->1
fall_pulse  out  WIDTH  one-cycle pulse per bit on accepted 1->0
change_flag  out  1  sticky; set by any accepted transition
flag_ack  in  1  clears change_flag

Behaviour:
- Interface: one clock (clk_clk); reset (reset_reset) is synchronous and active-high.
- Reset values:
  - sync1, sync2 and debounced_export = RESET_VALUE.
  - All counters = 0.
  - rise_pulse = 0, fall_pulse = 0, change_flag = 0.
- Synchronizer: sync1 <= raw_in; sync2 <= sync1. No logic between the two stages.
- Per-bit two-state FSM:
  - STABLE: sync2 == debounced.
    - Counter held at 0.
    - On mismatch -> PENDING, counter <= 1.
  - PENDING: sync2 != debounced.
    - If the mismatch persists and counter == STABLE_CYCLES-1: debounced <= sync2, counter <= 0, -> STABLE.
    - Else if the mismatch persists: counter += 1.
    - If the match returns (bounce): counter <= 0, -> STABLE, no output change.
- Counter semantics: debounced flips on the edge where the mismatch has been sampled on STABLE_CYCLES consecutive edges. Counter never exceeds STABLE_CYCLES-1, so no wrap is possible.
- Latency: if raw_in changes before edge k and is held, debounced_export shows the new value after edge k+STABLE_CYCLES+1. That is STABLE_CYCLES+2 edges total.
- STABLE_CYCLES == 1: debounced follows sync2 with one cycle of delay; the PENDING dwell is zero.
- Pulses:
  - rise_pulse[i] and fall_pulse[i] are registered.
  - Each is high for exactly the first cycle in which debounced_export[i] shows its new value.
  - Never both high for the same bit.
- Channels are fully independent; any number of bits may pulse in the same cycle.
- change_flag:
  - Set if any bit of (rise_pulse | fall_pulse) is set this cycle.
  - Cleared by flag_ack.
  - Set and ack in the same cycle -> set wins (flag stays 1).
  - Ack while clear has no effect.
- Reset mid-count: reset aborts PENDING; the counter goes to 0 and no pulse is generated.
- If raw_in differs from RESET_VALUE after reset, normal debounce applies and a pulse is generated on acceptance.

Decomposition:
- Package input_debouncer_pkg:
  - DEFAULT_WIDTH, DEFAULT_STABLE_CYCLES constants.
  - Channel state enum {ST_STABLE, ST_PENDING}.
- Sub-module debounce_channel holds one bit's synchronizer, counter, FSM and edge pulses.
  - Parameters: STABLE_CYCLES, RESET_BIT.
  - Instantiated WIDTH times via generate.
- Top level instantiates the channels and holds the change_flag register.

Test Plan:
- Reset: run with STABLE_CYCLES=4 and RESET_VALUE=8'h00, raw_in=8'h00, reset held for 3 cycles -> all outputs 0, no pulses for 20 cycles.
- Clean press: raw_in[0] 0->1 before edge k and held -> debounced_export=8'h01 after edge k+5; rise_pulse=8'h01 for exactly that one cycle; change_flag=1 from the same cycle onward.
- Bounce: raw_in[3] toggles 1,0,1,0 with 2-cycle periods, then holds 1 -> no output change during the bounce; debounced_export[3]=1 exactly 6 edges after the final hold begins; exactly one rise_pulse.
- Simultaneous: raw_in 8'h00->8'hA5 while debounced=8'h00, all bits held -> rise_pulse=8'hA5 in a single cycle; fall_pulse=8'h00.
- Ack collision: flag_ack=1 in the same cycle fall_pulse[7]=1 -> change_flag stays 1; flag_ack alone on the next cycle -> change_flag=0 on the following cycle.
- Reset mid-count: raw_in[1]=1 for 3 cycles, then reset_reset pulses for 1 cycle, then raw_in[1] held -> no pulse before reset; debounce restarts from zero; debounced_export[1]=1 exactly 6 edges after the reset edge.
